// File: rtl/dot_product_engine.sv
// Streaming sigma.J dot-product engine.
// A sigma vector is latched once. The J column then arrives LANES elements
// per cycle. Each element is added when its sigma bit is 1 and subtracted
// when it is 0, and a single signed sum is returned on a valid/ready port.
module dot_product_engine #(
  parameter int VECTOR_SIZE      = 256,
  parameter int J_ELEMENT_WIDTH  = 4,
  parameter int LANES            = 16,
  parameter int J_SIGNED         = 0,
  parameter int INT_RESULT_WIDTH = J_ELEMENT_WIDTH + $clog2(VECTOR_SIZE) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_valid_i,
  output logic                               start_ready_o,
  input  logic [VECTOR_SIZE-1:0]             sigma_i,
  input  logic                               j_valid_i,
  output logic                               j_ready_o,
  input  logic [LANES*J_ELEMENT_WIDTH-1:0]   j_data_i,
  output logic                               dot_valid_o,
  input  logic                               dot_ready_i,
  output logic [INT_RESULT_WIDTH-1:0]        dot_o,
  output logic                               busy_o
);

  localparam int JW         = J_ELEMENT_WIDTH;
  localparam int RW         = INT_RESULT_WIDTH;
  localparam int NUM_CHUNKS = VECTOR_SIZE / LANES;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  generate
    if (VECTOR_SIZE % LANES != 0) begin : g_size_check
      $error("dot_product_engine: VECTOR_SIZE must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [VECTOR_SIZE-1:0]  r_sigma;
  logic [CNT_W-1:0]        r_cnt;
  logic [LANES-1:0]        w_sigma_chunk;
  logic                    w_start_hs;
  logic                    w_j_hs;
  logic signed [RW-1:0]    w_lane_sum_p0;
  logic signed [RW-1:0]    r_partial_p1;
  logic                    r_vld_p1;
  logic signed [RW-1:0]    r_acc_p2;

  // Widen one J element to the result width (sign- or zero-extension); wraps
  // silently if the result width is overridden narrower than the element.
  function automatic logic signed [RW-1:0] extend_elem(input logic [JW-1:0] e);
    logic signed [RW-1:0] v;
    if (J_SIGNED != 0) v = RW'($signed(e));
    else               v = RW'(e);
    return v;
  endfunction

  // Apply the sigma bit: 1 keeps the element, 0 negates it.
  function automatic logic signed [RW-1:0] signed_term(input logic [JW-1:0] e,
                                                       input logic         add);
    logic signed [RW-1:0] v;
    v = extend_elem(e);
    return add ? v : -v;
  endfunction

  assign w_start_hs    = (r_state == IDLE) && start_valid_i;
  assign w_j_hs        = (r_state == RUN) && j_valid_i;
  assign w_sigma_chunk = r_sigma[r_cnt*LANES +: LANES];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt   = r_state;
    start_ready_o = 1'b0;
    j_ready_o     = 1'b0;
    dot_valid_o   = 1'b0;
    busy_o        = 1'b1;
    case (r_state)
      IDLE: begin
        start_ready_o = 1'b1;
        busy_o        = 1'b0;
        if (start_valid_i) w_state_nxt = RUN;
      end
      RUN: begin
        j_ready_o = 1'b1;
        if (j_valid_i && (r_cnt == LAST_CHUNK)) w_state_nxt = DRAIN;
      end
      DRAIN: w_state_nxt = DONE;
      DONE: begin
        dot_valid_o = 1'b1;
        if (dot_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p0: signed lane sum of the current chunk.
  always_comb begin
    w_lane_sum_p0 = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane_sum_p0 = w_lane_sum_p0 + signed_term(j_data_i[k*JW +: JW], w_sigma_chunk[k]);
    end
  end

  // Sigma is only captured on the start handshake.
  always_ff @(posedge clk) begin
    if (w_start_hs) r_sigma <= sigma_i;
  end

  // Stage p1: register the lane sum; stage p2: fold it into the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_partial_p1 <= '0;
      r_vld_p1     <= 1'b0;
      r_acc_p2     <= '0;
    end else begin
      r_vld_p1 <= w_j_hs;
      if (w_j_hs) begin
        r_partial_p1 <= w_lane_sum_p0;
        r_cnt        <= r_cnt + 1'b1;
      end
      if (w_start_hs) begin
        r_cnt    <= '0;
        r_acc_p2 <= '0;
      end else if (r_vld_p1) begin
        r_acc_p2 <= r_acc_p2 + r_partial_p1;
      end
    end
  end

  assign dot_o = (r_state == DONE) ? r_acc_p2 : '0;

endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: an unsigned-J and a signed-J instance share
// one stimulus stream; results are compared with a plain-arithmetic sum.
module tb_dot_product_engine;
  localparam int VS = 256;
  localparam int JW = 4;
  localparam int LN = 16;
  localparam int NC = VS / LN;
  localparam int RW = JW + $clog2(VS) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start_valid_i;
  logic [VS-1:0]     sigma_i;
  logic              j_valid_i;
  logic [LN*JW-1:0]  j_data_i;
  logic              dot_ready_i;

  logic start_ready_u, j_ready_u, dot_valid_u, busy_u;
  logic start_ready_s, j_ready_s, dot_valid_s, busy_s;
  logic [RW-1:0] dot_u, dot_s;

  dot_product_engine #(.VECTOR_SIZE(VS), .J_ELEMENT_WIDTH(JW), .LANES(LN), .J_SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .start_valid_i(start_valid_i), .start_ready_o(start_ready_u),
    .sigma_i(sigma_i), .j_valid_i(j_valid_i), .j_ready_o(j_ready_u), .j_data_i(j_data_i),
    .dot_valid_o(dot_valid_u), .dot_ready_i(dot_ready_i), .dot_o(dot_u), .busy_o(busy_u));

  dot_product_engine #(.VECTOR_SIZE(VS), .J_ELEMENT_WIDTH(JW), .LANES(LN), .J_SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .start_valid_i(start_valid_i), .start_ready_o(start_ready_s),
    .sigma_i(sigma_i), .j_valid_i(j_valid_i), .j_ready_o(j_ready_s), .j_data_i(j_data_i),
    .dot_valid_o(dot_valid_s), .dot_ready_i(dot_ready_i), .dot_o(dot_s), .busy_o(busy_s));

  int nvec  = 0;
  int nfail = 0;
  int edges = 0;
  logic [VS-1:0] sig;
  logic [JW-1:0] jv [VS];

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] obs_dot(input bit sm);
    return sm ? 32'($signed(dot_s)) : 32'($signed(dot_u));
  endfunction

  function automatic logic obs_valid(input bit sm);
    return sm ? dot_valid_s : dot_valid_u;
  endfunction

  // Reference: sum over all elements of +/- J[i], wrapped to the result width.
  function automatic int ref_dot(input bit sm);
    int s = 0;
    logic signed [RW-1:0] w;
    for (int i = 0; i < VS; i++) begin
      int v;
      v = int'(jv[i]);
      if (sm && v >= (1 << (JW-1))) v = v - (1 << JW);
      s = sig[i] ? s + v : s - v;
    end
    w = s[RW-1:0];
    return int'(w);
  endfunction

  task automatic step();
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  task automatic start_vec(input string tag);
    chk({tag, "_start_ready"}, start_ready_u, 1);
    chk({tag, "_start_ready_s"}, start_ready_s, 1);
    start_valid_i = 1'b1;
    sigma_i       = sig;
    step();
    edges         = 0;
    start_valid_i = 1'b0;
    sigma_i       = {8{$urandom()}};
    chk({tag, "_busy"}, busy_u, 1);
    chk({tag, "_start_ready_run"}, start_ready_u, 0);
  endtask

  task automatic feed(input string tag, input bit gaps, input bit poke, input int upto);
    int c = 0;
    int guard = 0;
    while (c < upto && guard < 1000) begin
      chk({tag, "_j_ready"}, j_ready_u, 1);
      chk({tag, "_j_ready_s"}, j_ready_s, 1);
      chk({tag, "_no_early_valid"}, dot_valid_u, 0);
      j_valid_i = !(gaps && ($urandom_range(0, 2) == 0));
      for (int k = 0; k < LN; k++) j_data_i[k*JW +: JW] = jv[c*LN + k];
      if (poke) begin
        start_valid_i = 1'($urandom_range(0, 1));
        sigma_i       = ~sig;
      end
      step();
      if (j_valid_i) c++;
      guard++;
    end
    j_valid_i     = 1'b0;
    start_valid_i = 1'b0;
    chk({tag, "_chunks_taken"}, c, upto);
  endtask

  task automatic finish_vec(input string tag, input bit sm, input int exp,
                            input int exp_edges, input int hold);
    int g = 0;
    dot_ready_i = 1'b0;
    while (!obs_valid(sm) && g < 50) begin
      step();
      g++;
    end
    chk({tag, "_valid"}, obs_valid(sm), 1);
    if (exp_edges >= 0) chk({tag, "_latency"}, edges, exp_edges);
    chk({tag, "_dot"}, obs_dot(sm), exp);
    chk({tag, "_start_ready_done"}, start_ready_u, 0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold_valid"}, obs_valid(sm), 1);
      chk({tag, "_hold_dot"}, obs_dot(sm), exp);
    end
    dot_ready_i = 1'b1;
    step();
    dot_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, obs_valid(sm), 0);
    chk({tag, "_start_ready_after"}, start_ready_u, 1);
    chk({tag, "_idle_u"}, busy_u, 0);
    chk({tag, "_idle_s"}, busy_s, 0);
  endtask

  task automatic randomize_vec();
    for (int i = 0; i < VS; i++) begin
      jv[i]  = JW'($urandom());
      sig[i] = 1'($urandom());
    end
  endtask

  initial begin
    rst           = 1'b1;
    start_valid_i = 1'b0;
    sigma_i       = '0;
    j_valid_i     = 1'b0;
    j_data_i      = '0;
    dot_ready_i   = 1'b0;
    @(negedge clk);
    step();
    step();
    chk("rst_start_ready", start_ready_u, 1);
    chk("rst_j_ready", j_ready_u, 0);
    chk("rst_dot_valid", dot_valid_u, 0);
    chk("rst_dot", $signed(dot_u), 0);
    chk("rst_busy", busy_u, 0);
    rst = 1'b0;
    step();

    // all_add / all_sub / alt_10 on J[i] = i mod 16
    for (int i = 0; i < VS; i++) jv[i] = JW'(i % 16);
    sig = '1;
    start_vec("all_add"); feed("all_add", 0, 0, NC); finish_vec("all_add", 0, 1920, NC + 1, 0);
    sig = '0;
    start_vec("all_sub"); feed("all_sub", 0, 0, NC); finish_vec("all_sub", 0, -1920, NC + 1, 0);
    for (int i = 0; i < VS; i++) sig[i] = (i % 2 == 1);
    start_vec("alt_10"); feed("alt_10", 0, 0, NC); finish_vec("alt_10", 0, 128, NC + 1, 0);

    // max_magnitude
    for (int i = 0; i < VS; i++) jv[i] = 4'hF;
    sig = '1;
    start_vec("max_pos"); feed("max_pos", 0, 0, NC); finish_vec("max_pos", 0, 3840, NC + 1, 0);
    sig = '0;
    start_vec("max_neg"); feed("max_neg", 0, 0, NC); finish_vec("max_neg", 0, -3840, NC + 1, 0);

    // signed_mode on the J_SIGNED=1 instance
    for (int i = 0; i < VS; i++) jv[i] = 4'b1000;
    sig = '1;
    start_vec("sgn_all"); feed("sgn_all", 0, 0, NC); finish_vec("sgn_all", 1, -2048, NC + 1, 0);
    for (int i = 0; i < VS; i++) sig[i] = (i % 2 == 1);
    start_vec("sgn_alt"); feed("sgn_alt", 0, 0, NC); finish_vec("sgn_alt", 1, 0, NC + 1, 0);

    // handshake: random data, j_valid gaps, mid-RUN start pokes, 5-cycle stall
    for (int r = 0; r < 4; r++) begin
      bit sm;
      sm = (r % 2 == 1);
      randomize_vec();
      start_vec("hs");
      feed("hs", 1, 1, NC);
      finish_vec("hs", sm, ref_dot(sm), -1, 5);
    end

    // reset at chunk 7: discarded, never presented
    randomize_vec();
    start_vec("rstmid");
    feed("rstmid", 0, 0, 7);
    rst       = 1'b1;
    j_valid_i = 1'b1;
    for (int k = 0; k < LN; k++) j_data_i[k*JW +: JW] = jv[7*LN + k];
    step();
    rst = 1'b0;
    chk("rstmid_busy", busy_u, 0);
    chk("rstmid_start_ready", start_ready_u, 1);
    chk("rstmid_j_ready", j_ready_u, 0);
    chk("rstmid_valid", dot_valid_u, 0);
    for (int n = 0; n < 20; n++) begin
      step();
      chk("rstmid_no_valid", dot_valid_u, 0);
      chk("rstmid_no_valid_s", dot_valid_s, 0);
      chk("rstmid_stays_idle", busy_u, 0);
    end
    j_valid_i = 1'b0;
    randomize_vec();
    start_vec("post_rst");
    feed("post_rst", 1, 0, NC);
    finish_vec("post_rst", 0, ref_dot(0), -1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
